// File: rtl/dot_sched_pkg.sv
// rtl/dot_sched_pkg.sv - shared types and constants for the dot frame scheduler
package dot_sched_pkg;

    localparam int DOT_X_W     = 10;
    localparam int DOT_Y_W     = 9;
    localparam int FRAME_CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        ACK     = 2'd2
    } sched_state_t;

    typedef struct packed {
        logic               en;
        logic [DOT_X_W-1:0] x;
        logic [DOT_Y_W-1:0] y;
    } dot_entry_t;

endpackage

// File: rtl/dot_bank.sv
// rtl/dot_bank.sv - one bank of dot slots with write port, parallel load and hit compare
module dot_bank
    import dot_sched_pkg::*;
#(
    parameter int NUM_DOTS = 8,
    parameter int IDX_W    = $clog2(NUM_DOTS)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               we,
    input  logic [IDX_W-1:0]   wr_idx,
    input  dot_entry_t         wr_data,
    input  logic               load,
    input  dot_entry_t         load_data [NUM_DOTS],
    output dot_entry_t         entries   [NUM_DOTS],
    input  logic [DOT_X_W-1:0] pix_x,
    input  logic [DOT_Y_W-1:0] pix_y,
    output logic               hit
);

    // A bulk load only happens at a swap, when writes are blocked, so the
    // two ports never compete in practice; load still takes precedence.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_DOTS; i++) begin
                entries[i] <= '0;
            end
        end else if (load) begin
            for (int i = 0; i < NUM_DOTS; i++) begin
                entries[i] <= load_data[i];
            end
        end else if (we && (int'(wr_idx) < NUM_DOTS)) begin
            entries[wr_idx] <= wr_data;
        end
    end

    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < NUM_DOTS; i++) begin
            if (entries[i].en && entries[i].x == pix_x && entries[i].y == pix_y) begin
                hit = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dot_frame_scheduler.sv
// rtl/dot_frame_scheduler.sv - double-buffered dot positions swapped at frame boundaries
module dot_frame_scheduler
    import dot_sched_pkg::*;
#(
    parameter int NUM_DOTS = 8,
    parameter int X_W      = DOT_X_W,
    parameter int Y_W      = DOT_Y_W,
    parameter int IDX_W    = $clog2(NUM_DOTS)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   wr_valid,
    output logic                   wr_ready,
    input  logic [IDX_W-1:0]       wr_idx,
    input  logic [X_W-1:0]         wr_x,
    input  logic [Y_W-1:0]         wr_y,
    input  logic                   wr_en,
    input  logic                   commit_req,
    output logic                   commit_ack,
    input  logic                   screen_end,
    input  logic                   pix_en,
    input  logic [X_W-1:0]         pix_x,
    input  logic [Y_W-1:0]         pix_y,
    output logic                   is_dot,
    output logic [FRAME_CNT_W-1:0] frame_count
);

    sched_state_t state, state_next;
    logic         front;
    logic         screen_end_q;
    logic         boundary;
    logic         swap;
    logic         wr_accept;
    logic         hit_a, hit_b;
    dot_entry_t   wr_data;
    dot_entry_t   entries_a [NUM_DOTS];
    dot_entry_t   entries_b [NUM_DOTS];

    assign boundary  = screen_end && !screen_end_q;
    assign wr_accept = wr_valid && wr_ready;
    assign wr_data   = '{en: wr_en, x: wr_x, y: wr_y};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        swap       = 1'b0;
        wr_ready   = 1'b0;
        commit_ack = 1'b0;
        case (state)
            IDLE: begin
                wr_ready = 1'b1;
                if (commit_req) begin
                    state_next = PENDING;
                end
            end
            PENDING: begin
                if (boundary) begin
                    swap       = 1'b1;
                    state_next = ACK;
                end
            end
            ACK: begin
                commit_ack = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            front        <= 1'b0;
            screen_end_q <= 1'b0;
            frame_count  <= '0;
            is_dot       <= 1'b0;
        end else begin
            screen_end_q <= screen_end;
            if (swap) begin
                front <= ~front;
            end
            if (boundary) begin
                frame_count <= frame_count + 1'b1;
            end
            if (pix_en) begin
                is_dot <= front ? hit_b : hit_a;
            end
        end
    end

    // At a swap the outgoing front bank becomes the back bank and is refilled
    // from the incoming front, so later edits start from what is on screen.
    dot_bank #(.NUM_DOTS(NUM_DOTS), .IDX_W(IDX_W)) bank_a (
        .clk       (clk),
        .reset     (reset),
        .we        (wr_accept && front),
        .wr_idx    (wr_idx),
        .wr_data   (wr_data),
        .load      (swap && !front),
        .load_data (entries_b),
        .entries   (entries_a),
        .pix_x     (pix_x),
        .pix_y     (pix_y),
        .hit       (hit_a)
    );

    dot_bank #(.NUM_DOTS(NUM_DOTS), .IDX_W(IDX_W)) bank_b (
        .clk       (clk),
        .reset     (reset),
        .we        (wr_accept && !front),
        .wr_idx    (wr_idx),
        .wr_data   (wr_data),
        .load      (swap && front),
        .load_data (entries_a),
        .entries   (entries_b),
        .pix_x     (pix_x),
        .pix_y     (pix_y),
        .hit       (hit_b)
    );

endmodule

// File: tb/tb_dot_frame_scheduler.sv
// tb/tb_dot_frame_scheduler.sv - directed self-checking bench for dot_frame_scheduler
module tb_dot_frame_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic        wr_valid;
    logic        wr_ready;
    logic [2:0]  wr_idx;
    logic [9:0]  wr_x;
    logic [8:0]  wr_y;
    logic        wr_en;
    logic        commit_req;
    logic        commit_ack;
    logic        screen_end;
    logic        pix_en;
    logic [9:0]  pix_x;
    logic [8:0]  pix_y;
    logic        is_dot;
    logic [15:0] frame_count;

    int tests  = 0;
    int failed = 0;
    int exp_fc = 0;

    always #5 clk = ~clk;

    dot_frame_scheduler #(.NUM_DOTS(8), .X_W(10), .Y_W(9)) dut (
        .clk         (clk),
        .reset       (reset),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_idx      (wr_idx),
        .wr_x        (wr_x),
        .wr_y        (wr_y),
        .wr_en       (wr_en),
        .commit_req  (commit_req),
        .commit_ack  (commit_ack),
        .screen_end  (screen_end),
        .pix_en      (pix_en),
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .is_dot      (is_dot),
        .frame_count (frame_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic write_slot(input int idx, input int x, input int y, input logic en);
        wr_valid = 1'b1;
        wr_idx   = idx[2:0];
        wr_x     = x[9:0];
        wr_y     = y[8:0];
        wr_en    = en;
        @(negedge clk);
        wr_valid = 1'b0;
    endtask

    task automatic probe(input string tag, input int x, input int y, input logic expv);
        pix_en = 1'b1;
        pix_x  = x[9:0];
        pix_y  = y[8:0];
        @(negedge clk);
        pix_en = 1'b0;
        check(tag, {31'd0, is_dot}, {31'd0, expv});
    endtask

    task automatic commit(input string tag);
        commit_req = 1'b1;
        @(negedge clk);
        commit_req = 1'b0;
        check(tag, {31'd0, wr_ready}, 32'd0);
    endtask

    task automatic boundary(input string tag, input logic expect_ack);
        screen_end = 1'b1;
        @(negedge clk);
        exp_fc = (exp_fc + 1) & 16'hFFFF;
        check({tag, "_ack"}, {31'd0, commit_ack}, {31'd0, expect_ack});
        check({tag, "_fc"}, {16'd0, frame_count}, exp_fc);
        repeat (3) begin
            @(negedge clk);
            check({tag, "_ack_low"}, {31'd0, commit_ack}, 32'd0);
        end
        screen_end = 1'b0;
        @(negedge clk);
        check({tag, "_fc_hold"}, {16'd0, frame_count}, exp_fc);
        check({tag, "_ready"}, {31'd0, wr_ready}, 32'd1);
    endtask

    initial begin
        reset = 1'b1; wr_valid = 1'b0; wr_idx = '0; wr_x = '0; wr_y = '0; wr_en = 1'b0;
        commit_req = 1'b0; screen_end = 1'b0; pix_en = 1'b0; pix_x = '0; pix_y = '0;
        repeat (2) @(negedge clk);
        check("rst_ready", {31'd0, wr_ready}, 32'd1);
        check("rst_ack", {31'd0, commit_ack}, 32'd0);
        check("rst_isdot", {31'd0, is_dot}, 32'd0);
        check("rst_fc", {16'd0, frame_count}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // uncommitted write is invisible, then visible after swap
        write_slot(0, 310, 50, 1'b1);
        probe("pre_commit_hit", 310, 50, 1'b0);
        commit("commit1_ready");
        boundary("swap1", 1'b1);
        probe("post_swap_hit", 310, 50, 1'b1);
        probe("post_swap_miss", 311, 50, 1'b0);

        // commit and write while pending are ignored
        commit("commit2_ready");
        commit_req = 1'b1;
        wr_valid = 1'b1; wr_idx = 3'd2; wr_x = 10'd100; wr_y = 9'd100; wr_en = 1'b1;
        @(negedge clk);
        check("pending_ready", {31'd0, wr_ready}, 32'd0);
        commit_req = 1'b0;
        wr_valid = 1'b0;
        boundary("swap2", 1'b1);
        probe("pending_write_dropped", 100, 100, 1'b0);
        probe("back_copy_keeps_slot0", 310, 50, 1'b1);

        // set then clear slot 3 across two swaps
        write_slot(3, 5, 5, 1'b1);
        commit("commit3_ready");
        boundary("swap3", 1'b1);
        probe("slot3_on", 5, 5, 1'b1);
        write_slot(3, 5, 5, 1'b0);
        commit("commit4_ready");
        boundary("swap4", 1'b1);
        probe("slot3_off", 5, 5, 1'b0);
        probe("slot0_preserved", 310, 50, 1'b1);

        // write and commit in the same cycle
        wr_valid = 1'b1; wr_idx = 3'd1; wr_x = 10'd639; wr_y = 9'd479; wr_en = 1'b1;
        commit_req = 1'b1;
        @(negedge clk);
        wr_valid = 1'b0;
        commit_req = 1'b0;
        check("same_cycle_ready", {31'd0, wr_ready}, 32'd0);
        boundary("swap5", 1'b1);
        probe("corner_hit", 639, 479, 1'b1);

        // commit on the boundary edge waits for the next frame
        commit_req = 1'b1;
        screen_end = 1'b1;
        @(negedge clk);
        commit_req = 1'b0;
        exp_fc = exp_fc + 1;
        check("edge_commit_no_ack", {31'd0, commit_ack}, 32'd0);
        check("edge_commit_pending", {31'd0, wr_ready}, 32'd0);
        repeat (3) @(negedge clk);
        check("edge_commit_still_no_ack", {31'd0, commit_ack}, 32'd0);
        screen_end = 1'b0;
        @(negedge clk);
        check("hold_fc_once", {16'd0, frame_count}, exp_fc);
        boundary("swap6", 1'b1);

        // reset while pending clears everything
        probe("pre_reset_hit", 639, 479, 1'b1);
        write_slot(4, 1, 1, 1'b1);
        commit("commit7_ready");
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        exp_fc = 0;
        check("mid_rst_ready", {31'd0, wr_ready}, 32'd1);
        check("mid_rst_isdot", {31'd0, is_dot}, 32'd0);
        check("mid_rst_fc", {16'd0, frame_count}, 32'd0);
        boundary("post_rst", 1'b0);
        probe("post_rst_banks_clear", 639, 479, 1'b0);
        probe("post_rst_slot4", 1, 1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/dot_frame_scheduler.md
# dot_frame_scheduler

Double-buffered dot-position controller between the processor and the VGA pixel path. The processor writes dot positions into a back bank at any time. It then requests a commit, and the block swaps banks only at a frame boundary (`screen_end`), so a frame never shows a half-updated set. The block also provides the per-pixel `is_dot` hit signal the colour mux consumes, and reports frame completion back to the processor.

## Interface
Parameters:
- `NUM_DOTS`, 8: number of dot slots per bank; power of two, at least 2.
- `X_W`, 10: x coordinate width (covers 640).
- `Y_W`, 9: y coordinate width (covers 480).
- `IDX_W`, `$clog2(NUM_DOTS)`: slot index width.

Ports:
- `clk` in 1: 100 MHz system clock. Single clock domain.
- `reset` in 1: asynchronous, active-high reset.
- `wr_valid` in 1: processor write request.
- `wr_ready` out 1: block can accept a write.
- `wr_idx` in IDX_W: slot to write.
- `wr_x` in X_W, `wr_y` in Y_W: new dot position.
- `wr_en` in 1: slot enable bit written with the position; 0 hides the dot.
- `commit_req` in 1: single-cycle pulse requesting a bank swap at the next frame boundary.
- `commit_ack` out 1: single-cycle pulse when the swap has taken effect.
- `screen_end` in 1: level from the timing generator, high for one 25 MHz period (4 `clk`) between frames.
- `pix_en` in 1: 25 MHz pixel strobe, one `clk` cycle wide.
- `pix_x` in X_W, `pix_y` in Y_W: current pixel coordinate.
- `is_dot` out 1: registered hit flag for the pixel sampled at the last `pix_en`.
- `frame_count` out 16: count of frame boundaries seen.

## Operation
- Two banks, A and B. Each holds `NUM_DOTS` entries of {en, x, y}.
- `front` bit selects the displayed bank. Writes always target the back bank.
- States:
  - IDLE: `wr_ready=1`.
  - PENDING: `wr_ready=0`. The back bank is frozen and waits for the boundary.
  - ACK: one cycle. `commit_ack=1`, `wr_ready=0`.
- Transitions:
  - IDLE→PENDING on `commit_req`.
  - PENDING→ACK on the `screen_end` rising edge.
  - ACK→IDLE unconditionally.
- Write handshake: a write is accepted when `wr_valid && wr_ready`. The entry is updated at that clock edge.
- Out-of-range `wr_idx` (≥ `NUM_DOTS`) is accepted and discarded.
- Swap, at the clock edge where PENDING sees the boundary edge:
  - `front` toggles.
  - The new back bank is loaded with a copy of the new front bank in the same edge, so later writes edit the displayed set incrementally.
- Simultaneous `wr_valid` and `commit_req` in IDLE: both are taken. The write lands and is included in the commit.
- `commit_req` in PENDING or ACK is ignored.
- `commit_req` in IDLE on the same cycle as a boundary edge enters PENDING and waits for the next boundary.
- Hit test: on `pix_en`, `is_dot <= OR over front entries of (en && x==pix_x && y==pix_y)`. Between strobes `is_dot` holds.
- `frame_count` increments on every `screen_end` rising edge and wraps at 16'hFFFF→0.
- Reset values:
  - State IDLE, `front=0`.
  - All entries {0,0,0} in both banks.
  - `wr_ready=1`, `commit_ack=0`, `is_dot=0`, `frame_count=0`.
  - Edge-detect register 0.
- Reset mid-operation discards any pending commit and all bank contents.

## Timing
- Boundary edge is defined as the cycle where `screen_end=1` and the previous cycle's `screen_end=0`. Call it cycle e.
- Boundary handling at cycle e:
  - In PENDING, the swap occurs at the end of e.
  - `commit_ack` is high in e+1.
  - A `pix_en` in e+1 uses the new front bank.
- `frame_count` shows the new value from e+1.
- `is_dot` latency: 1 `clk` after the `pix_en` cycle.
- `wr_ready` drops in the cycle after `commit_req` is taken. It rises in the cycle after ACK.
- A write accepted at t is visible to the hit test only after a subsequent commit.

## Structure
- Shared package `dot_sched_pkg`:
  - state enum {IDLE, PENDING, ACK};
  - `dot_entry_t` packed struct {en, x[X_W], y[Y_W]};
  - `FRAME_CNT_W = 16`.
- Sub-module `dot_bank`: one `NUM_DOTS` register file with write port, parallel load input and combinational hit compare. Two instances; the top level holds the FSM, edge detect, `front`, and the output registers.

## Test plan
- Reset, then write slot 0 = {1,310,50}, no commit; pixel (310,50) on `pix_en` → `is_dot=0`. Commit and pulse `screen_end` → `commit_ack` in e+1; the next `pix_en` at (310,50) gives `is_dot=1` one cycle later; (311,50) → 0.
- `commit_req` in PENDING, then wr_valid in PENDING → `wr_ready=0`, write not accepted, single `commit_ack` at next boundary.
- Write slot 3 = {1,5,5}, commit, boundary; write slot 3 = {0,5,5}, commit, boundary → (5,5) hit after first swap, no hit after second; untouched slots are preserved across both swaps through the back-copy.
- `wr_valid` + `commit_req` same cycle with slot 1 = {1,639,479} → the write is included; (639,479) hits after the boundary.
- `commit_req` on the same cycle as the boundary edge → no ack that frame; ack after the next edge. `screen_end` held 4 cycles → `frame_count` +1 only.
- Assert `reset` while PENDING → IDLE, `wr_ready=1`, `is_dot=0`, `frame_count=0`, no `commit_ack` at the next boundary.
